// File: rtl/stream_to_bram_capture.sv
// stream_to_bram_capture
//
// Captures a burst of 32-bit AXI-stream beats into a BRAM through a native
// BRAM write port. A capture is armed by a single-cycle pulse, starts either
// immediately or on the first beat that coincides with an orbit-sync pulse,
// and completes after a programmable number of words. The input stream is
// always drained; beats that arrive outside a capture are dropped.
//
// Ports
//   clk, rst              sole clock, asynchronous active-high reset
//   fc_orbitSync          orbit sync pulse (used as the start qualifier in mode 1)
//   cfg_mode              1 = orbit-aligned start, anything else = immediate start
//   cfg_len               words to capture, 0 (or anything above MEM_DEPTH) = MEM_DEPTH
//   cfg_arm, cfg_abort    single-cycle control pulses; abort has priority
//   data_stream_*         AXI-stream sink (TREADY is high whenever out of reset)
//   bram_*                BRAM write port; writes are issued in the handshake cycle
//   status_busy           registered, high in ARMED or CAPTURE
//   status_done           registered, high once a capture has completed
//   status_words          registered, words written by the current or last capture

module stream_to_bram_capture #(
  parameter int unsigned MEM_DEPTH = 2048
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fc_orbitSync,
  input  logic [1:0]  cfg_mode,
  input  logic [15:0] cfg_len,
  input  logic        cfg_arm,
  input  logic        cfg_abort,
  input  logic [31:0] data_stream_TDATA,
  input  logic        data_stream_TVALID,
  output logic        data_stream_TREADY,
  output logic        bram_CLK,
  output logic        bram_RST,
  output logic        bram_EN,
  output logic [3:0]  bram_WE,
  output logic [31:0] bram_ADDR,
  output logic [31:0] bram_DIN,
  output logic        status_busy,
  output logic        status_done,
  output logic [15:0] status_words
);

  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StCapture,
    StDone
  } state_e;

  // Lengths are kept one bit wider than cfg_len so MEM_DEPTH itself is
  // representable and the completion compare never wraps.
  localparam logic [16:0] DepthLen = 17'(MEM_DEPTH);

  state_e      state_q, state_d;
  logic [15:0] words_q, words_d;
  logic [16:0] eff_len_q, eff_len_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;

  logic [16:0] cfg_len_ext;
  logic [16:0] eff_len_cfg;
  logic [16:0] words_inc;
  logic        start_ok;
  logic        wr_en;

  // Effective capture length, sampled into eff_len_q only on arm.
  always_comb begin
    cfg_len_ext = {1'b0, cfg_len};
    if ((cfg_len == 16'd0) || (cfg_len_ext > DepthLen)) begin
      eff_len_cfg = DepthLen;
    end else begin
      eff_len_cfg = cfg_len_ext;
    end
  end

  // Mode is checked live every cycle, so a mode change while armed applies
  // to the very next start check.
  assign start_ok  = (cfg_mode != 2'd1) || fc_orbitSync;
  assign words_inc = {1'b0, words_q} + 17'd1;

  // Next-state logic. wr_en is the combinational write strobe for the
  // current handshake cycle.
  always_comb begin
    state_d   = state_q;
    words_d   = words_q;
    eff_len_d = eff_len_q;
    wr_en     = 1'b0;

    if (cfg_abort) begin
      // Abort wins over arm and over any write in the same cycle; the word
      // count is kept so software can see how far the capture got.
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (cfg_arm) begin
            state_d   = StArmed;
            words_d   = 16'd0;
            eff_len_d = eff_len_cfg;
          end
        end
        StArmed: begin
          if (data_stream_TVALID && start_ok) begin
            wr_en   = 1'b1;
            words_d = words_inc[15:0];
            // A one-word capture completes on its start beat.
            state_d = (words_inc == eff_len_q) ? StDone : StCapture;
          end
        end
        StCapture: begin
          // Gap cycles (TVALID low) simply hold here.
          if (data_stream_TVALID) begin
            wr_en   = 1'b1;
            words_d = words_inc[15:0];
            if (words_inc == eff_len_q) begin
              state_d = StDone;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Status flags are registered views of the next state.
  always_comb begin
    done_d = (state_d == StDone);
    busy_d = (state_d == StArmed) || (state_d == StCapture);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      words_q   <= 16'd0;
      eff_len_q <= DepthLen;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      words_q   <= words_d;
      eff_len_q <= eff_len_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  // Write port. The reset term makes the strobes drop the instant reset is
  // asserted, independent of the clock.
  assign bram_CLK  = clk;
  assign bram_RST  = rst;
  assign bram_EN   = wr_en & ~rst;
  assign bram_WE   = {4{wr_en & ~rst}};
  assign bram_ADDR = {14'd0, words_q, 2'b00};
  assign bram_DIN  = data_stream_TDATA;

  assign data_stream_TREADY = ~rst;

  assign status_busy  = busy_q;
  assign status_done  = done_q;
  assign status_words = words_q;

endmodule

// File: tb/tb_stream_to_bram_capture.sv
module tb_stream_to_bram_capture;

  localparam int unsigned Depth = 2048;

  logic        clk = 1'b0;
  logic        rst;
  logic        fc_orbitSync;
  logic [1:0]  cfg_mode;
  logic [15:0] cfg_len;
  logic        cfg_arm;
  logic        cfg_abort;
  logic [31:0] data_stream_TDATA;
  logic        data_stream_TVALID;
  logic        data_stream_TREADY;
  logic        bram_CLK;
  logic        bram_RST;
  logic        bram_EN;
  logic [3:0]  bram_WE;
  logic [31:0] bram_ADDR;
  logic [31:0] bram_DIN;
  logic        status_busy;
  logic        status_done;
  logic [15:0] status_words;

  stream_to_bram_capture #(
    .MEM_DEPTH(Depth)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .fc_orbitSync      (fc_orbitSync),
    .cfg_mode          (cfg_mode),
    .cfg_len           (cfg_len),
    .cfg_arm           (cfg_arm),
    .cfg_abort         (cfg_abort),
    .data_stream_TDATA (data_stream_TDATA),
    .data_stream_TVALID(data_stream_TVALID),
    .data_stream_TREADY(data_stream_TREADY),
    .bram_CLK          (bram_CLK),
    .bram_RST          (bram_RST),
    .bram_EN           (bram_EN),
    .bram_WE           (bram_WE),
    .bram_ADDR         (bram_ADDR),
    .bram_DIN          (bram_DIN),
    .status_busy       (status_busy),
    .status_done       (status_done),
    .status_words      (status_words)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic        arm;
    logic        abort;
    logic [1:0]  mode;
    logic [15:0] len;
    logic        valid;
    logic        sync;
    logic [31:0] data;
    logic        exp_wr;
    logic [31:0] exp_addr;
    logic [15:0] exp_words;
    logic        exp_done;
    logic        exp_busy;
  } vec_t;

  wr_t  exp_q[$];
  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic check_status(input string tag, input logic [15:0] words, input logic done,
                              input logic busy);
    check({tag, "_words"}, {16'd0, status_words}, {16'd0, words});
    check({tag, "_done"}, {31'd0, status_done}, {31'd0, done});
    check({tag, "_busy"}, {31'd0, status_busy}, {31'd0, busy});
  endtask

  // One clock cycle. Inputs are already driven (posedge+2); the write port
  // is scored at the falling edge against the scoreboard head.
  task automatic tick();
    wr_t e;
    @(negedge clk);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("write_strobe", {27'd0, bram_EN, bram_WE}, 32'h1F);
      check("write_addr", bram_ADDR, e.addr);
      check("write_data", bram_DIN, e.data);
    end else begin
      check("no_write", {27'd0, bram_EN, bram_WE}, 32'h0);
    end
    @(posedge clk);
    #2;
  endtask

  task automatic push_wr(input logic [31:0] addr, input logic [31:0] data);
    wr_t e;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic arm(input logic [1:0] mode, input logic [15:0] len);
    cfg_mode = mode;
    cfg_len  = len;
    cfg_arm  = 1'b1;
    tick();
    cfg_arm = 1'b0;
  endtask

  task automatic beat(input logic [31:0] d, input logic exp_wr, input logic [31:0] addr);
    data_stream_TVALID = 1'b1;
    data_stream_TDATA  = d;
    if (exp_wr) push_wr(addr, d);
    tick();
    data_stream_TVALID = 1'b0;
  endtask

  function automatic void add(input logic arm_i, input logic [1:0] mode, input logic [15:0] len,
                              input logic valid, input logic sync, input logic [31:0] data,
                              input logic exp_wr, input logic [31:0] exp_addr,
                              input logic [15:0] exp_words, input logic exp_done,
                              input logic exp_busy);
    vec_t v;
    v.arm = arm_i;   v.abort = 1'b0; v.mode = mode; v.len = len;
    v.valid = valid; v.sync = sync;  v.data = data;
    v.exp_wr = exp_wr; v.exp_addr = exp_addr; v.exp_words = exp_words;
    v.exp_done = exp_done; v.exp_busy = exp_busy;
    vecs.push_back(v);
  endfunction

  initial begin
    rst                = 1'b1;
    fc_orbitSync       = 1'b0;
    cfg_mode           = 2'd0;
    cfg_len            = 16'd0;
    cfg_arm            = 1'b0;
    cfg_abort          = 1'b0;
    data_stream_TDATA  = 32'd0;
    data_stream_TVALID = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    check("reset_tready", {31'd0, data_stream_TREADY}, 32'd0);
    check("reset_we", {27'd0, bram_EN, bram_WE}, 32'd0);
    check_status("reset", 16'd0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    check("tready_run", {31'd0, data_stream_TREADY}, 32'd1);

    // Immediate mode, 4 words, 5th beat dropped
    add(1, 0, 4, 0, 0, 32'h0,  0, 32'h0, 0, 0, 1);
    add(0, 0, 4, 1, 0, 32'hA0, 1, 32'h0, 1, 0, 1);
    add(0, 0, 4, 1, 0, 32'hA1, 1, 32'h4, 2, 0, 1);
    add(0, 0, 4, 1, 0, 32'hA2, 1, 32'h8, 3, 0, 1);
    add(0, 0, 4, 1, 0, 32'hA3, 1, 32'hC, 4, 1, 0);
    add(0, 0, 4, 1, 0, 32'hA4, 0, 32'h0, 4, 1, 0);
    // Orbit-aligned, 3 words: nothing until the sync beat, then sync is not needed
    add(1, 1, 3, 0, 0, 32'h0, 0, 32'h0, 0, 0, 1);
    for (int i = 0; i < 10; i++) add(0, 1, 3, 1, 0, 32'(i), 0, 32'h0, 0, 0, 1);
    add(0, 1, 3, 1, 1, 32'h55, 1, 32'h0, 1, 0, 1);
    add(0, 1, 3, 1, 0, 32'h56, 1, 32'h4, 2, 0, 1);
    add(0, 1, 3, 0, 0, 32'h99, 0, 32'h0, 2, 0, 1);
    add(0, 1, 3, 1, 0, 32'h57, 1, 32'h8, 3, 1, 0);
    // Mode change while armed applies next cycle; cfg_len change after arm ignored
    add(1, 1, 2,   0, 0, 32'h0,  0, 32'h0, 0, 0, 1);
    add(0, 1, 2,   1, 0, 32'h76, 0, 32'h0, 0, 0, 1);
    add(0, 0, 100, 1, 0, 32'h77, 1, 32'h0, 1, 0, 1);
    add(0, 1, 100, 1, 0, 32'h78, 1, 32'h4, 2, 1, 0);

    foreach (vecs[i]) begin
      cfg_arm            = vecs[i].arm;
      cfg_abort          = vecs[i].abort;
      cfg_mode           = vecs[i].mode;
      cfg_len            = vecs[i].len;
      data_stream_TVALID = vecs[i].valid;
      fc_orbitSync       = vecs[i].sync;
      data_stream_TDATA  = vecs[i].data;
      if (vecs[i].exp_wr) push_wr(vecs[i].exp_addr, vecs[i].data);
      tick();
      check_status($sformatf("vec%0d", i), vecs[i].exp_words, vecs[i].exp_done,
                   vecs[i].exp_busy);
    end
    cfg_arm = 1'b0; data_stream_TVALID = 1'b0; fc_orbitSync = 1'b0; cfg_mode = 2'd0;

    // Zero length -> full depth, with a gap after every beat
    arm(2'd0, 16'd0);
    cfg_len = 16'd5;
    for (int i = 0; i < int'(Depth); i++) begin
      beat(32'hC000_0000 | i, 1'b1, 32'(i) << 2);
      if (i == int'(Depth) - 2) check_status("zl_before_last", 16'(Depth - 1), 1'b0, 1'b1);
      tick();
    end
    check_status("zl_end", 16'(Depth), 1'b1, 1'b0);
    beat(32'hDEAD, 1'b0, 32'h0);

    // Abort together with arm at word 5
    arm(2'd0, 16'd10);
    for (int i = 0; i < 5; i++) beat(32'hB0 + i, 1'b1, 32'(i) << 2);
    cfg_abort = 1'b1; cfg_arm = 1'b1; data_stream_TVALID = 1'b1; data_stream_TDATA = 32'hBAD;
    tick();
    cfg_abort = 1'b0; cfg_arm = 1'b0; data_stream_TVALID = 1'b0;
    check_status("abort", 16'd5, 1'b0, 1'b0);
    beat(32'hBB, 1'b0, 32'h0);
    arm(2'd0, 16'd3);
    check_status("rearm", 16'd0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) beat(32'hE0 + i, 1'b1, 32'(i) << 2);
    check_status("rearm_end", 16'd3, 1'b1, 1'b0);

    // Reset at word 7
    arm(2'd0, 16'd20);
    for (int i = 0; i < 7; i++) beat(32'hF0 + i, 1'b1, 32'(i) << 2);
    data_stream_TVALID = 1'b1; data_stream_TDATA = 32'hF7;
    rst = 1'b1;
    #1;
    check("rst_async_we", {27'd0, bram_EN, bram_WE}, 32'd0);
    check("rst_async_tready", {31'd0, data_stream_TREADY}, 32'd0);
    check_status("rst_async", 16'd0, 1'b0, 1'b0);
    data_stream_TVALID = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) beat(32'h1F0 + i, 1'b0, 32'h0);
    check_status("post_rst", 16'd0, 1'b0, 1'b0);

    // Oversized length clamps to full depth
    arm(2'd0, 16'd5000);
    for (int i = 0; i < int'(Depth); i++) begin
      beat(32'h5000_0000 | i, 1'b1, 32'(i) << 2);
      if (i == int'(Depth) - 2) check_status("big_before_last", 16'(Depth - 1), 1'b0, 1'b1);
    end
    check_status("big_end", 16'(Depth), 1'b1, 1'b0);
    beat(32'h5EAD, 1'b0, 32'h0);

    // Length 1: done on the start beat
    arm(2'd3, 16'd1);
    beat(32'h1234_5678, 1'b1, 32'h0);
    check_status("len1", 16'd1, 1'b1, 1'b0);
    beat(32'h8765_4321, 1'b0, 32'h0);

    // Abort from DONE clears done and keeps the count
    cfg_abort = 1'b1;
    tick();
    cfg_abort = 1'b0;
    check_status("abort_done", 16'd1, 1'b0, 1'b0);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
